// File: rtl/sv32_pkg.sv
// Shared sv32 physical-side definitions: address width, bridge state encoding
// and the window-membership helper used by the bridge and future PMP logic.
package sv32_pkg;

    localparam int PA_W = 34;

    typedef enum logic [2:0] {
        BR_IDLE  = 3'd0,
        BR_ISSUE = 3'd1,
        BR_WAIT  = 3'd2,
        BR_RESP  = 3'd3,
        BR_TURN  = 3'd4
    } bridge_state_e;

    // The limit is formed in PA_W+1 bits so a window ending at the top of the
    // physical space does not wrap to zero.
    function automatic logic pa_in_window(input logic [PA_W-1:0] addr,
                                          input logic [PA_W-1:0] base,
                                          input logic [PA_W:0]   size);
        logic [PA_W:0] limit;
        limit = {1'b0, base} + size;
        return (addr >= base) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/sv32_phys_mem_bridge_pa_range_check.sv
// Combinational base/limit compare of a physical address against one window.
module pa_range_check
    import sv32_pkg::*;
#(
    parameter logic [PA_W-1:0] BASE = '0,
    parameter logic [PA_W:0]   SIZE = 35'h0_4_0000
) (
    input  logic [PA_W-1:0] addr,
    output logic            in_range
);

    assign in_range = pa_in_window(addr, BASE, SIZE);

endmodule

// File: rtl/sv32_phys_mem_bridge.sv
// Bridge from the sv32 MMU physical memory port to a synchronous block RAM,
// with window check, configurable read latency and debug access/fault counters.
//
//   state | meaning
//   IDLE  | waiting for mem_valid; request sampled and range-checked here
//   ISSUE | address/data/byte enables presented to the RAM for one cycle
//   WAIT  | read latency down-count; ram_dout captured at terminal count
//   RESP  | mem_ready strobe, access_fault if out of window
//   TURN  | master drops mem_valid; request ignored
module sv32_phys_mem_bridge
    import sv32_pkg::*;
#(
    parameter logic [PA_W-1:0] ADDR_BASE  = 34'h0_0000_0000,
    parameter int              RAM_AW     = 16,
    parameter int              RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [3:0]        mem_wstrb,
    input  logic [PA_W-1:0]   mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              access_fault,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [31:0]       access_count,
    output logic [31:0]       fault_count
);

    localparam logic [2:0]    IDLE     = BR_IDLE;
    localparam logic [2:0]    ISSUE    = BR_ISSUE;
    localparam logic [2:0]    WAIT     = BR_WAIT;
    localparam logic [2:0]    RESP     = BR_RESP;
    localparam logic [2:0]    TURN     = BR_TURN;
    localparam logic [PA_W:0] WIN_SIZE = (PA_W+1)'(4) << RAM_AW;
    localparam logic [2:0]    LAT_INIT = 3'(RD_LATENCY);

    logic [2:0]      state;
    logic [2:0]      lat_cnt;
    logic            is_write;
    logic            fault;
    logic            in_range;
    logic [PA_W-1:0] off;
    logic            unused_off;

    pa_range_check #(
        .BASE (ADDR_BASE),
        .SIZE (WIN_SIZE)
    ) u_range (
        .addr     (mem_addr),
        .in_range (in_range)
    );

    assign off          = mem_addr - ADDR_BASE;
    assign unused_off   = ^{off[PA_W-1:RAM_AW+2], off[1:0]};
    assign mem_ready    = (state == RESP);
    assign access_fault = (state == RESP) && fault;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            is_write     <= 1'b0;
            fault        <= 1'b0;
            mem_rdata    <= '0;
            ram_addr     <= '0;
            ram_we       <= '0;
            ram_din      <= '0;
            access_count <= '0;
            fault_count  <= '0;
        end else begin
            // Byte enables are a single-cycle pulse that only IDLE can raise.
            ram_we <= '0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        is_write <= (mem_wstrb != 4'h0);
                        fault    <= !in_range;
                        if (in_range) begin
                            ram_addr <= off[RAM_AW+1:2];
                            ram_din  <= mem_wdata;
                            ram_we   <= mem_wstrb;
                            state    <= ISSUE;
                        end else begin
                            if (mem_wstrb == 4'h0) begin
                                mem_rdata <= '0;
                            end
                            state <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_INIT;
                    state   <= is_write ? RESP : WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (lat_cnt == 3'd1) begin
                        mem_rdata <= ram_dout;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (fault) begin
                        fault_count <= fault_count + 32'd1;
                    end else begin
                        access_count <= access_count + 32'd1;
                    end
                    state <= TURN;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sv32_phys_mem_bridge.sv
// Directed bench: one bridge with read latency 1 and one with latency 2, each
// backed by a behavioural synchronous RAM.
module tb_sv32_phys_mem_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;

    logic        a_valid = 1'b0, a_ready, a_fault;
    logic [3:0]  a_wstrb = 4'h0, a_ram_we;
    logic [33:0] a_addr = '0;
    logic [31:0] a_wdata = '0, a_rdata, a_ram_din, a_ram_dout, a_acc, a_flt;
    logic [15:0] a_ram_addr;

    logic        b_valid = 1'b0, b_ready, b_fault;
    logic [3:0]  b_wstrb = 4'h0, b_ram_we;
    logic [33:0] b_addr = '0;
    logic [31:0] b_wdata = '0, b_rdata, b_ram_din, b_ram_dout, b_acc, b_flt;
    logic [15:0] b_ram_addr;

    logic [31:0] mem_a [0:65535];
    logic [31:0] mem_b [0:65535];
    logic [31:0] b_p1;

    int          n_checks = 0;
    int          n_pass = 0;
    int          rcyc;
    logic [31:0] r_rdata;
    logic        r_fault;
    logic [3:0]  c1_we;
    logic [15:0] c1_addr;
    bit          we_seen;

    sv32_phys_mem_bridge #(.RD_LATENCY(1)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(a_valid), .mem_ready(a_ready),
        .mem_wstrb(a_wstrb), .mem_addr(a_addr), .mem_wdata(a_wdata),
        .mem_rdata(a_rdata), .access_fault(a_fault), .ram_addr(a_ram_addr),
        .ram_we(a_ram_we), .ram_din(a_ram_din), .ram_dout(a_ram_dout),
        .access_count(a_acc), .fault_count(a_flt)
    );

    sv32_phys_mem_bridge #(.RD_LATENCY(2)) dut_lat2 (
        .clk(clk), .resetn(resetn), .mem_valid(b_valid), .mem_ready(b_ready),
        .mem_wstrb(b_wstrb), .mem_addr(b_addr), .mem_wdata(b_wdata),
        .mem_rdata(b_rdata), .access_fault(b_fault), .ram_addr(b_ram_addr),
        .ram_we(b_ram_we), .ram_din(b_ram_din), .ram_dout(b_ram_dout),
        .access_count(b_acc), .fault_count(b_flt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (a_ram_we[i]) mem_a[a_ram_addr][i*8 +: 8] <= a_ram_din[i*8 +: 8];
        a_ram_dout <= mem_a[a_ram_addr];
    end

    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (b_ram_we[j]) mem_b[b_ram_addr][j*8 +: 8] <= b_ram_din[j*8 +: 8];
        b_p1       <= mem_b[b_ram_addr];
        b_ram_dout <= b_p1;
    end

    // Issues one request; cycle 0 is the first cycle mem_valid is seen in IDLE.
    task automatic do_req(input bit sel, input logic [33:0] addr,
                          input logic [31:0] wd, input logic [3:0] ws);
        int cyc;
        bit done;
        @(posedge clk); #1;
        if (!sel) begin
            a_valid = 1'b1; a_addr = addr; a_wdata = wd; a_wstrb = ws;
        end else begin
            b_valid = 1'b1; b_addr = addr; b_wdata = wd; b_wstrb = ws;
        end
        cyc = 0; done = 0; rcyc = -1; we_seen = 0;
        c1_we = 'x; c1_addr = 'x; r_rdata = 'x; r_fault = 1'bx;
        while (!done && cyc < 20) begin
            @(negedge clk);
            if (cyc == 1) begin
                c1_we   = sel ? b_ram_we : a_ram_we;
                c1_addr = sel ? b_ram_addr : a_ram_addr;
            end
            if ((sel ? b_ram_we : a_ram_we) != 4'h0) we_seen = 1;
            if (sel ? b_ready : a_ready) begin
                done    = 1;
                rcyc    = cyc;
                r_rdata = sel ? b_rdata : a_rdata;
                r_fault = sel ? b_fault : a_fault;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #2;
        n_checks++;
        if ({a_ready, a_fault, a_ram_we} !== 6'h0) $display("FAIL reset_ctrl: got %h expected 00", {a_ready, a_fault, a_ram_we});
        else n_pass++;
        n_checks++;
        if ({a_rdata, a_ram_din, a_ram_addr} !== 80'h0) $display("FAIL reset_data: got %h expected 0", {a_rdata, a_ram_din, a_ram_addr});
        else n_pass++;
        n_checks++;
        if ({a_acc, a_flt, b_acc, b_flt} !== 128'h0) $display("FAIL reset_counts: got %h expected 0", {a_acc, a_flt, b_acc, b_flt});
        else n_pass++;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic test_write;
        do_req(0, 34'h0_0001_0000, 32'hAAAA_BBBB, 4'hF);
        n_checks++;
        if (c1_we !== 4'hF) $display("FAIL write_we_c1: got %h expected f", c1_we);
        else n_pass++;
        n_checks++;
        if (c1_addr !== 16'h4000) $display("FAIL write_addr_c1: got %h expected 4000", c1_addr);
        else n_pass++;
        n_checks++;
        if (rcyc !== 2) $display("FAIL write_latency: got %0d expected 2", rcyc);
        else n_pass++;
        n_checks++;
        if (a_acc !== 32'd1) $display("FAIL write_count: got %0d expected 1", a_acc);
        else n_pass++;
    endtask

    task automatic test_read_latency;
        do_req(0, 34'h0_0001_0000, 32'h0, 4'h0);
        n_checks++;
        if (rcyc !== 3) $display("FAIL read_lat1_cycle: got %0d expected 3", rcyc);
        else n_pass++;
        n_checks++;
        if (r_rdata !== 32'hAAAA_BBBB || r_fault !== 1'b0) $display("FAIL read_lat1_data: got %h/%b expected aaaabbbb/0", r_rdata, r_fault);
        else n_pass++;
        do_req(1, 34'h0_0001_0000, 32'hAAAA_BBBB, 4'hF);
        n_checks++;
        if (rcyc !== 2) $display("FAIL lat2_write_cycle: got %0d expected 2", rcyc);
        else n_pass++;
        do_req(1, 34'h0_0001_0000, 32'h0, 4'h0);
        n_checks++;
        if (rcyc !== 4) $display("FAIL read_lat2_cycle: got %0d expected 4", rcyc);
        else n_pass++;
        n_checks++;
        if (r_rdata !== 32'hAAAA_BBBB) $display("FAIL read_lat2_data: got %h expected aaaabbbb", r_rdata);
        else n_pass++;
    endtask

    task automatic test_partial_write;
        do_req(0, 34'h0_0000_0100, 32'hFFFF_FFFF, 4'hF);
        do_req(0, 34'h0_0000_0100, 32'h1122_3344, 4'b0101);
        n_checks++;
        if (c1_we !== 4'b0101) $display("FAIL partial_we: got %b expected 0101", c1_we);
        else n_pass++;
        do_req(0, 34'h0_0000_0100, 32'h0, 4'h0);
        n_checks++;
        if (r_rdata !== 32'hFF22_FF44) $display("FAIL partial_readback: got %h expected ff22ff44", r_rdata);
        else n_pass++;
    endtask

    task automatic test_window_edges;
        do_req(0, 34'h0_0003_FFFC, 32'h0BAD_F00D, 4'hF);
        n_checks++;
        if (c1_addr !== 16'hFFFF || rcyc !== 2) $display("FAIL last_word_write: got %h/%0d expected ffff/2", c1_addr, rcyc);
        else n_pass++;
        do_req(0, 34'h0_0003_FFFC, 32'h0, 4'h0);
        n_checks++;
        if (r_rdata !== 32'h0BAD_F00D || r_fault !== 1'b0) $display("FAIL last_word_read: got %h/%b expected 0badf00d/0", r_rdata, r_fault);
        else n_pass++;
        do_req(0, 34'h0_0001_0000, 32'h0, 4'h0);
        do_req(0, 34'h0_0004_0000, 32'h0, 4'h0);
        n_checks++;
        if (rcyc !== 1 || r_fault !== 1'b1) $display("FAIL fault_past_window: got %0d/%b expected 1/1", rcyc, r_fault);
        else n_pass++;
        n_checks++;
        if (we_seen !== 1'b0 || r_rdata !== 32'h0) $display("FAIL fault_read_side: got we=%b rdata=%h expected we=0 rdata=0", we_seen, r_rdata);
        else n_pass++;
        do_req(0, 34'h3_FFFF_FFFC, 32'h1234_5678, 4'hF);
        n_checks++;
        if (rcyc !== 1 || r_fault !== 1'b1 || we_seen !== 1'b0) $display("FAIL fault_top: got %0d/%b we=%b expected 1/1 we=0", rcyc, r_fault, we_seen);
        else n_pass++;
        n_checks++;
        if (a_flt !== 32'd2 || a_acc !== 32'd8) $display("FAIL fault_counts: got flt=%0d acc=%0d expected flt=2 acc=8", a_flt, a_acc);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int          rdy1, rdy2;
        logic [31:0] din1, din5;
        logic [3:0]  we5;
        bit          consec;
        logic        prev;
        rdy1 = -1; rdy2 = -1; prev = 1'b0; consec = 0;
        din1 = 'x; din5 = 'x; we5 = 'x;
        @(posedge clk); #1;
        a_valid = 1'b1; a_wstrb = 4'hF; a_addr = 34'h0_0000_0200; a_wdata = 32'hCAFE_0001;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) din1 = a_ram_din;
            if (c == 5) begin din5 = a_ram_din; we5 = a_ram_we; end
            if (a_ready && prev) consec = 1;
            prev = a_ready;
            if (a_ready) begin
                if (rdy1 < 0) rdy1 = c;
                else if (rdy2 < 0) rdy2 = c;
            end
            @(posedge clk); #1;
            if (c == 0) a_wdata = 32'hCAFE_0002;
            if (c == 6) a_valid = 1'b0;
        end
        n_checks++;
        if (rdy1 !== 2 || rdy2 !== 6) $display("FAIL b2b_ready_cycles: got %0d,%0d expected 2,6", rdy1, rdy2);
        else n_pass++;
        n_checks++;
        if (we5 !== 4'hF || din1 !== 32'hCAFE_0001 || din5 !== 32'hCAFE_0002) $display("FAIL b2b_issue: got we5=%h din1=%h din5=%h expected f cafe0001 cafe0002", we5, din1, din5);
        else n_pass++;
        n_checks++;
        if (consec !== 0 || a_acc !== 32'd10) $display("FAIL b2b_ready_count: got consec=%0d acc=%0d expected 0 10", consec, a_acc);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit saw;
        do_req(0, 34'h0_0001_0000, 32'h0, 4'h0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_wstrb = 4'hF; a_addr = 34'h0_0000_0300; a_wdata = 32'h5555_6666;
        @(posedge clk); #2;
        n_checks++;
        if (a_ram_we !== 4'hF) $display("FAIL issue_we_before_reset: got %h expected f", a_ram_we);
        else n_pass++;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (a_ram_we !== 4'h0 || a_ram_din !== 32'h0 || a_rdata !== 32'h0) $display("FAIL reset_in_issue: got we=%h din=%h rdata=%h expected 0", a_ram_we, a_ram_din, a_rdata);
        else n_pass++;
        a_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        do_req(0, 34'h0_0001_0000, 32'h0, 4'h0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_wstrb = 4'h0; a_addr = 34'h0_0001_0000;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (a_ready !== 1'b0 || a_rdata !== 32'h0 || a_ram_addr !== 16'h0 || a_acc !== 32'h0) $display("FAIL reset_in_wait: got rdy=%b rdata=%h addr=%h acc=%0d expected 0", a_ready, a_rdata, a_ram_addr, a_acc);
        else n_pass++;
        a_valid = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        saw = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (a_ready) saw = 1;
        end
        n_checks++;
        if (saw !== 0) $display("FAIL no_resp_after_abort: got %0d expected 0", saw);
        else n_pass++;
        do_req(0, 34'h0_0001_0000, 32'h0, 4'h0);
        n_checks++;
        if (rcyc !== 3 || r_rdata !== 32'hAAAA_BBBB || a_acc !== 32'd1) $display("FAIL read_after_reset: got %0d/%h/%0d expected 3/aaaabbbb/1", rcyc, r_rdata, a_acc);
        else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_write();
        test_read_latency();
        test_partial_write();
        test_window_edges();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
